// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the fetch controller and pc_sequencer.
// The master drives the sequencing controls; the slave returns the fetch address and stack status.
interface pc_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int LANES  = 4
);
    localparam int LW = $clog2(LANES);

    logic              vector;
    logic [LW-1:0]     lane_offset;
    logic              stall;
    logic              flush;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;
    logic              call_en;
    logic              ret_en;
    logic [ADDR_W-1:0] address;
    logic              stack_empty;
    logic              stack_full;
    logic              stack_err;

    modport master (
        output vector, lane_offset, stall, flush, jump_en, jump_addr, call_en, ret_en,
        input  address, stack_empty, stack_full, stack_err
    );

    modport slave (
        input  vector, lane_offset, stall, flush, jump_en, jump_addr, call_en, ret_en,
        output address, stack_empty, stack_full, stack_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// Instruction-fetch program sequencer for the SIMD array: lane-gated advance, jump, flush, stall.
// Define PC_CALL_STACK_EN to build the hardware call/return stack; without it call acts as jump.
module pc_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int RESET_ADDR  = 15,
    parameter int LANES       = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    pc_sequencer_if.slave bus
);
    localparam int                LW        = $clog2(LANES);
    localparam logic [ADDR_W-1:0] BOOT      = ADDR_W'(RESET_ADDR);
    localparam logic [LW-1:0]     LAST_LANE = LW'(LANES - 1);

    if (LANES < 2 || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
        $error("pc_sequencer: LANES must be a power of two >= 2");
    end
    if (STACK_DEPTH < 1) begin : g_bad_depth
        $error("pc_sequencer: STACK_DEPTH must be >= 1");
    end

    logic              adv;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;

    // Scalar groups only move the PC once the last lane has issued.
    assign adv         = !bus.stall && (bus.vector || bus.lane_offset == LAST_LANE);
    assign pc_inc      = pc_q + ADDR_W'(1);
    assign bus.address = pc_q;

`ifdef PC_CALL_STACK_EN
    localparam int            DW     = $clog2(STACK_DEPTH + 1);
    localparam logic [DW-1:0] FULL_D = DW'(STACK_DEPTH);

    // Sized to the depth counter's range so it can index the array directly.
    logic [ADDR_W-1:0] stack_mem [2**DW];
    logic [DW-1:0]     depth_q, depth_d, top_idx;
    logic              err_q, err_d, push;

    assign top_idx = depth_q - DW'(1);

    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        err_d   = err_q;
        push    = 1'b0;
        if (!bus.stall) begin
            if (bus.flush) begin
                pc_d    = BOOT;
                depth_d = '0;
                err_d   = 1'b0;
            end else if (adv) begin
                if (bus.ret_en) begin
                    if (depth_q != '0) begin
                        pc_d    = stack_mem[top_idx];
                        depth_d = top_idx;
                    end else begin
                        pc_d  = pc_inc;
                        err_d = 1'b1;
                    end
                end else if (bus.call_en) begin
                    if (depth_q != FULL_D) begin
                        pc_d    = bus.jump_addr;
                        depth_d = depth_q + DW'(1);
                        push    = 1'b1;
                    end else begin
                        pc_d  = pc_inc;
                        err_d = 1'b1;
                    end
                end else if (bus.jump_en) begin
                    pc_d = bus.jump_addr;
                end else begin
                    pc_d = pc_inc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) stack_mem[depth_q] <= pc_inc;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= BOOT;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    assign bus.stack_empty = (depth_q == '0);
    assign bus.stack_full  = (depth_q == FULL_D);
    assign bus.stack_err   = err_q;
`else
    logic unused_ret;
    assign unused_ret = bus.ret_en;

    always_comb begin
        pc_d = pc_q;
        if (!bus.stall) begin
            if (bus.flush)                          pc_d = BOOT;
            else if (adv && (bus.call_en || bus.jump_en)) pc_d = bus.jump_addr;
            else if (adv)                           pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pc_q <= BOOT;
        else          pc_q <= pc_d;
    end

    assign bus.stack_empty = 1'b1;
    assign bus.stack_full  = 1'b0;
    assign bus.stack_err   = 1'b0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer; stack scenarios run when PC_CALL_STACK_EN is defined.
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_W(8), .LANES(4)) bus ();

    pc_sequencer #(.ADDR_W(8), .RESET_ADDR(15), .LANES(4), .STACK_DEPTH(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] lo, input logic st, input logic fl,
                         input logic je, input logic [7:0] ja, input logic ce, input logic re);
        bus.vector      = v;
        bus.lane_offset = lo;
        bus.stall       = st;
        bus.flush       = fl;
        bus.jump_en     = je;
        bus.jump_addr   = ja;
        bus.call_en     = ce;
        bus.ret_en      = re;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One advancing vector cycle with the given control-flow request.
    task automatic vstep(input logic je, input logic [7:0] ja, input logic ce, input logic re);
        drive(1'b1, 2'd0, 1'b0, 1'b0, je, ja, ce, re);
        tick();
    endtask

    task automatic async_reset_check();
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_addr", bus.address, 32'd15);
        chk("async_rst_empty", bus.stack_empty, 32'd1);
        chk("async_rst_err", bus.stack_err, 32'd0);
        @(negedge clk);
        chk("rst_hold_addr", bus.address, 32'd15);
        reset_n = 1'b1;
        vstep(1'b0, 8'h00, 1'b0, 1'b0);
        chk("post_rst_inc", bus.address, 32'd16);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #12;
        chk("rst_addr", bus.address, 32'd15);
        chk("rst_empty", bus.stack_empty, 32'd1);
        chk("rst_full", bus.stack_full, 32'd0);
        chk("rst_err", bus.stack_err, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 1; i <= 20; i++) begin
            vstep(1'b0, 8'h00, 1'b0, 1'b0);
            chk("vec_inc", bus.address, 32'(15 + i));
        end

        vstep(1'b1, 8'hFE, 1'b0, 1'b0);
        chk("jump_fe", bus.address, 32'hFE);
        vstep(1'b0, 8'h00, 1'b0, 1'b0);
        chk("inc_ff", bus.address, 32'hFF);
        vstep(1'b0, 8'h00, 1'b0, 1'b0);
        chk("wrap_00", bus.address, 32'h00);

        for (int r = 0; r < 2; r++) begin
            for (int l = 0; l < 4; l++) begin
                drive(1'b0, 2'(l), 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
                tick();
                chk("lane_gate", bus.address, 32'(r + ((l == 3) ? 1 : 0)));
            end
        end

        drive(1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        chk("stall_lane3", bus.address, 32'd2);
        drive(1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        chk("stall_flush", bus.address, 32'd2);
        drive(1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
        tick();
        chk("stall_jump", bus.address, 32'd2);
        drive(1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
        tick();
        chk("noadv_jump", bus.address, 32'd2);
        drive(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 8'h77, 1'b1, 1'b0);
        tick();
        chk("noadv_call", bus.address, 32'd2);
        chk("noadv_call_empty", bus.stack_empty, 32'd1);
        drive(1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        chk("flush_noadv", bus.address, 32'd15);
        vstep(1'b1, 8'h20, 1'b0, 1'b0);
        drive(1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0);
        tick();
        chk("flush_over_jump", bus.address, 32'd15);

        vstep(1'b1, 8'h20, 1'b0, 1'b0);
        chk("jump_20", bus.address, 32'h20);
        vstep(1'b0, 8'h80, 1'b1, 1'b0);
        chk("call_80", bus.address, 32'h80);
`ifdef PC_CALL_STACK_EN
        chk("call_not_empty", bus.stack_empty, 32'd0);
`endif
        for (int i = 1; i <= 3; i++) begin
            vstep(1'b0, 8'h00, 1'b0, 1'b0);
            chk("sub_inc", bus.address, 32'(8'h80 + i));
        end
        vstep(1'b0, 8'h00, 1'b0, 1'b1);
`ifdef PC_CALL_STACK_EN
        chk("ret_21", bus.address, 32'h21);
        chk("ret_empty", bus.stack_empty, 32'd1);
        chk("ret_err", bus.stack_err, 32'd0);

        vstep(1'b1, 8'h30, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            vstep(1'b0, 8'(8'h60 + 16 * i), 1'b1, 1'b0);
            chk("nest_call", bus.address, 32'(8'h60 + 16 * i));
            chk("nest_full", bus.stack_full, 32'((i == 3) ? 1 : 0));
            chk("nest_err", bus.stack_err, 32'd0);
        end
        vstep(1'b0, 8'hA0, 1'b1, 1'b0);
        chk("ovf_addr", bus.address, 32'h91);
        chk("ovf_err", bus.stack_err, 32'd1);
        chk("ovf_full", bus.stack_full, 32'd1);
        vstep(1'b0, 8'h00, 1'b0, 1'b1);
        chk("pop_81", bus.address, 32'h81);
        chk("pop_not_full", bus.stack_full, 32'd0);
        chk("err_sticky", bus.stack_err, 32'd1);
        drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        chk("flush_addr", bus.address, 32'd15);
        chk("flush_err", bus.stack_err, 32'd0);
        chk("flush_empty", bus.stack_empty, 32'd1);

        vstep(1'b1, 8'h40, 1'b0, 1'b0);
        vstep(1'b0, 8'h00, 1'b0, 1'b1);
        chk("unf_addr", bus.address, 32'h41);
        chk("unf_err", bus.stack_err, 32'd1);
        chk("unf_empty", bus.stack_empty, 32'd1);
        drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();

        vstep(1'b1, 8'h10, 1'b0, 1'b0);
        vstep(1'b0, 8'h70, 1'b1, 1'b0);
        chk("one_call", bus.address, 32'h70);
        vstep(1'b0, 8'h99, 1'b1, 1'b1);
        chk("callret_addr", bus.address, 32'h11);
        chk("callret_empty", bus.stack_empty, 32'd1);
        chk("callret_err", bus.stack_err, 32'd0);
        vstep(1'b0, 8'h00, 1'b0, 1'b1);
        chk("callret_nopush", bus.address, 32'h12);
        chk("callret_nopush_err", bus.stack_err, 32'd1);

        drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        vstep(1'b0, 8'h50, 1'b1, 1'b0);
        vstep(1'b0, 8'h60, 1'b1, 1'b0);
        chk("depth2_addr", bus.address, 32'h60);
        chk("depth2_empty", bus.stack_empty, 32'd0);
`else
        chk("ret_ignored", bus.address, 32'h84);
        vstep(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ret_inc", bus.address, 32'h85);
        chk("tie_empty", bus.stack_empty, 32'd1);
        chk("tie_full", bus.stack_full, 32'd0);
        chk("tie_err", bus.stack_err, 32'd0);
        vstep(1'b0, 8'h50, 1'b1, 1'b0);
        chk("call_as_jump", bus.address, 32'h50);
`endif
        async_reset_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program sequencer for the SIMD array processor's instruction fetch path, generalising the fixed 8-bit program counter. It holds the fetch address, advances only on vector instructions or when the last lane of a scalar group issues, and supports jumps, a synchronous flush to the boot address, a global stall, and an optional hardware call/return stack. The output address drives the instruction memory read port directly.

## Interface
Parameters:
- ADDR_W, 8, width of the fetch address
- RESET_ADDR, 15, boot/flush address, truncated to ADDR_W bits
- LANES, 4, lanes per scalar group; must be a power of two ≥ 2
- STACK_DEPTH, 4, call-stack entries; must be ≥ 1; ignored when stack compiled out

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- vector  in  1  current instruction is a vector op; advance unconditionally
- lane_offset  in  $clog2(LANES)  lane index of current scalar op
- stall  in  1  freeze sequencer this cycle
- flush  in  1  synchronous reload of RESET_ADDR
- jump_en  in  1  load jump_addr
- jump_addr  in  ADDR_W  jump/call target
- call_en  in  1  push return address, load jump_addr
- ret_en  in  1  pop return address into PC
- address  out  ADDR_W  current fetch address (registered)
- stack_empty  out  1  stack holds 0 entries
- stack_full  out  1  stack holds STACK_DEPTH entries
- stack_err  out  1  sticky: overflow or underflow occurred

## Operation
- Advance cycle: adv = !stall && (vector || lane_offset == LANES-1). On non-advance cycles all state holds and jump_en/call_en/ret_en are ignored (not queued).
- flush acts whenever !stall, regardless of adv: address ← RESET_ADDR, stack emptied, stack_err cleared.
- On adv, priority (highest first): ret_en, call_en, jump_en, increment.
- ret_en, stack non-empty: address ← top entry, depth −1.
- ret_en, stack empty: stack_err ← 1, address ← address+1.
- call_en, stack not full: push address+1 (mod 2^ADDR_W), address ← jump_addr, depth +1.
- call_en, stack full: no push, stack_err ← 1, address ← address+1.
- call_en and ret_en together: ret wins, call dropped with no error.
- jump_en: address ← jump_addr.
- Increment: address ← address+1, wraps 2^ADDR_W−1 → 0.
- stack_empty = (depth == 0), stack_full = (depth == STACK_DEPTH); both combinational from registered depth.
- stack_err cleared only by reset_n or flush.

## Timing
- reset_n low: immediately address = RESET_ADDR, depth = 0, stack_empty = 1, stack_full = 0, stack_err = 0. Release is synchronised by the SoC; block acts on first rising edge with reset_n high.
- All updates occur on the rising edge of the cycle in which the control is sampled; address reflects them one cycle later (latency 1, no bypass).
- stall has priority over everything except reset_n, including flush.
- stack_err asserts the cycle after the offending edge and stays high.
- Reset mid-call/ret: stack contents discarded, depth 0.

## Configuration
- PC_CALL_STACK_EN defined: call/return stack, stack_empty/full/err behaviour as above.
- Undefined: no stack storage; call_en behaves as jump_en (target loaded, nothing pushed); ret_en ignored (treated as increment); stack_empty tied 1, stack_full tied 0, stack_err tied 0.

## Test plan
- Reset then 20 vector=1 cycles -> address 15,16,…,35; 0xFF increments to 0x00.
- vector=0, lane_offset 0,1,2,3 repeated -> address increments only after lane_offset=3 cycles; stall=1 with lane_offset=3 -> address holds.
- At address 0x20 call_en, jump_addr=0x80; 3 increments; ret_en -> address 0x80,0x81,0x82,0x83, then 0x21; stack_empty back to 1.
- Five nested calls with STACK_DEPTH=4 -> stack_full after fourth, fifth call ignores target, address+1, stack_err=1; flush -> address 15, stack_err 0, stack_empty 1.
- ret_en on empty stack at 0x40 -> address 0x41, stack_err=1; call_en+ret_en same cycle with one entry -> pop taken, depth 0, no push.
- reset_n pulsed low asynchronously mid-cycle with depth 2 -> address 15 before next edge, stack_empty 1; macro undefined run: call_en to 0x80 -> 0x80, ret_en -> 0x81.
